divider: RTL and testbench

DIVIDER -- requirements
Module: divider

---
 rtl/divider.sv | 254 +++++++++++++++++++++++++
 tb/tb_divider.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/divider.sv
// ---------------------------------------------------------------------------
// divider -- 32-bit iterative integer divider (radix-2 restoring)
//
// Computes signed/unsigned quotient or remainder, one quotient bit per clock.
// A request in IDLE captures the operands and the sign-fixup flags, BUSY runs
// 32 shift/subtract iterations over a 64-bit remainder:quotient register, and
// DONE presents the result for exactly one cycle with ready high.
//
// Ports:
//   clk    in   1  sole clock, all state updates on the rising edge
//   rst    in   1  synchronous active-low reset
//   divsel in   3  000 none, 001 div, 010 divu, 011 rem, 100 remu, else none
//   a      in  32  dividend, sampled only when an operation starts
//   b      in  32  divisor,  sampled only when an operation starts
//   ready  out  1  result-valid strobe, high in DONE only
//   res    out 32  quotient (div/divu) or remainder (rem/remu), held until
//                  the next completed operation
//
// Behaviour notes:
//   - divsel falling back to "none" while BUSY aborts; res is left untouched.
//   - Divide-by-zero: quotient 0xFFFFFFFF for every op, remainder = raw a.
//   - Signed overflow (0x80000000 / -1): quotient 0x80000000, remainder 0.
//
// Configuration macro:
//   DIV_EARLY_OUT_EN  when defined, divide-by-zero and signed overflow skip
//                     BUSY and go IDLE -> DONE directly (ready in cycle 1).
//                     When undefined every operation takes the full 33-cycle
//                     latency and the special results are applied at DONE.
// ---------------------------------------------------------------------------
module divider (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  divsel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        ready,
  output logic [31:0] res
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_DIV  = 3'd1,
    OP_DIVU = 3'd2,
    OP_REM  = 3'd3,
    OP_REMU = 3'd4
  } op_e;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  // -------------------------------------------------------------------------
  // Result selection and sign fixup. Shared by the normal completion path
  // and the early-out path so both produce identical special-case results.
  // -------------------------------------------------------------------------
  function automatic logic [31:0] final_result(
    input op_e         op,
    input logic        neg_quot,
    input logic        neg_rem,
    input logic        b_zero,
    input logic        ovf,
    input logic [31:0] dividend,
    input logic [31:0] quot,
    input logic [31:0] rem
  );
    logic is_rem;
    is_rem = (op == OP_REM) || (op == OP_REMU);
    if (b_zero) begin
      return is_rem ? dividend : ALL_ONES;
    end
    if (ovf) begin
      return is_rem ? 32'h0 : INT_MIN;
    end
    if (is_rem) begin
      return neg_rem ? (~rem + 32'd1) : rem;
    end
    return neg_quot ? (~quot + 32'd1) : quot;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e      state_q,    state_d;
  op_e         op_q,       op_d;
  logic        neg_quot_q, neg_quot_d;   // quotient negated at the end
  logic        neg_rem_q,  neg_rem_d;    // remainder negated at the end
  logic        b_zero_q,   b_zero_d;
  logic        ovf_q,      ovf_d;
  logic [31:0] a_q,        a_d;          // raw dividend for rem-by-zero
  logic [31:0] divisor_q,  divisor_d;    // divisor magnitude
  logic [63:0] rq_q,       rq_d;         // {remainder, quotient}
  logic [5:0]  cnt_q,      cnt_d;
  logic [31:0] res_q,      res_d;

  // -------------------------------------------------------------------------
  // Request decode (valid only while IDLE, but also used as the abort test
  // during BUSY)
  // -------------------------------------------------------------------------
  op_e         req_op;
  logic        req_valid;
  logic        req_signed;
  logic        req_b_zero;
  logic        req_ovf;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  always_comb begin
    case (divsel)
      3'd1:    req_op = OP_DIV;
      3'd2:    req_op = OP_DIVU;
      3'd3:    req_op = OP_REM;
      3'd4:    req_op = OP_REMU;
      default: req_op = OP_NONE;
    endcase
  end

  assign req_valid  = (req_op != OP_NONE);
  assign req_signed = (req_op == OP_DIV) || (req_op == OP_REM);
  assign req_b_zero = (b == 32'h0);
  assign req_ovf    = req_signed && (a == INT_MIN) && (b == ALL_ONES);

  // Two's-complement magnitude for signed ops. INT_MIN maps onto itself,
  // which read as unsigned is exactly 2^31, so no special case is needed.
  assign a_mag = (req_signed && a[31]) ? (~a + 32'd1) : a;
  assign b_mag = (req_signed && b[31]) ? (~b + 32'd1) : b;

  // -------------------------------------------------------------------------
  // One restoring iteration. After the left shift the partial remainder
  // occupies 33 bits (the old remainder MSB plus 32 bits), i.e. rq_q[63:31].
  // A clear borrow means the trial subtraction is kept and the quotient bit
  // is 1; if the shifted-out bit was set the subtraction always succeeds, so
  // the discarded path never loses information.
  // -------------------------------------------------------------------------
  logic [32:0] trial;
  logic        trial_ok;
  logic [63:0] rq_step;

  assign trial    = rq_q[63:31] - {1'b0, divisor_q};
  assign trial_ok = ~trial[32];
  assign rq_step  = trial_ok ? {trial[31:0], rq_q[30:0], 1'b1}
                             : {rq_q[62:0], 1'b0};

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    b_zero_d   = b_zero_q;
    ovf_d      = ovf_q;
    a_d        = a_q;
    divisor_d  = divisor_q;
    rq_d       = rq_q;
    cnt_d      = cnt_q;
    res_d      = res_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d       = req_op;
          neg_quot_d = req_signed && (a[31] ^ b[31]);
          neg_rem_d  = req_signed && a[31];
          b_zero_d   = req_b_zero;
          ovf_d      = req_ovf;
          a_d        = a;
          divisor_d  = b_mag;
          rq_d       = {32'h0, a_mag};
          cnt_d      = 6'd0;
          state_d    = BUSY;
`ifdef DIV_EARLY_OUT_EN
          if (req_b_zero || req_ovf) begin
            state_d = DONE;
            res_d   = final_result(req_op, 1'b0, 1'b0, req_b_zero, req_ovf,
                                   a, 32'h0, 32'h0);
          end
`endif
        end
      end

      BUSY: begin
        if (!req_valid) begin
          // Abort: drop the operation, keep the previous result visible.
          state_d = IDLE;
        end else begin
          rq_d  = rq_step;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_d = DONE;
            res_d   = final_result(op_q, neg_quot_q, neg_rem_q, b_zero_q,
                                   ovf_q, a_q, rq_step[31:0], rq_step[63:32]);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers. Reset is synchronous and wins over every state,
  // including DONE, so a reset edge never lets a ready pulse through.
  // -------------------------------------------------------------------------
  // NOTE: non-blocking assignments so every register samples the values
  // from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      op_q       <= OP_NONE;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      b_zero_q   <= 1'b0;
      ovf_q      <= 1'b0;
      a_q        <= 32'h0;
      divisor_q  <= 32'h0;
      rq_q       <= 64'h0;
      cnt_q      <= 6'd0;
      res_q      <= 32'h0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      b_zero_q   <= b_zero_d;
      ovf_q      <= ovf_d;
      a_q        <= a_d;
      divisor_q  <= divisor_d;
      rq_q       <= rq_d;
      cnt_q      <= cnt_d;
      res_q      <= res_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign ready = (state_q == DONE);
  assign res   = res_q;

endmodule

// File: tb/tb_divider.sv
// ---------------------------------------------------------------------------
// tb_divider -- scoreboard bench for divider
//
// The driver applies directed operations with hand-computed results and
// pushes {expected res, expected ready cycle} into a queue. An independent
// monitor pops an entry on every ready pulse and compares value and cycle;
// a ready pulse with nothing queued is reported as unexpected. Cycle N is
// the interval after the N-th rising clock edge; an op whose divsel is first
// valid in cycle N expects ready in cycle N + latency.
// ---------------------------------------------------------------------------
module tb_divider;

`ifdef DIV_EARLY_OUT_EN
  localparam int LAT_SPECIAL = 1;
`else
  localparam int LAT_SPECIAL = 33;
`endif
  localparam int LAT_NORMAL = 33;

  logic        clk;
  logic        rst;
  logic [2:0]  divsel;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready;
  logic [31:0] res;

  divider dut (
    .clk    (clk),
    .rst    (rst),
    .divsel (divsel),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .res    (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    string       name;
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];

  task automatic sb_push(input string name, input logic [31:0] r,
                         input int c);
    exp_t e;
    e.name = name;
    e.res  = r;
    e.cyc  = c;
    sb_q.push_back(e);
  endtask

  // Monitor: samples 2 time units after each rising edge.
  logic prev_ready = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (ready === 1'b1) begin
        check("ready_one_cycle", {31'h0, prev_ready}, 32'h0);
        if (sb_q.size() == 0) begin
          check("unexpected_ready", {31'h0, ready}, 32'h0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check({e.name, "_res"}, res, e.res);
          check({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
        end
      end
      prev_ready = (ready === 1'b1);
    end
  end

  // ---------------- driver helpers ----------------
  // Called 1 time unit after an edge with the DUT idle; returns likewise.
  task automatic run_op(input string name, input logic [2:0] sel,
                        input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] exp_res, input int lat,
                        input bit scramble);
    divsel = sel;
    a      = av;
    b      = bv;
    sb_push(name, exp_res, cyc + lat);
    for (int i = 0; i < lat; i++) begin
      @(posedge clk);
      #1;
      if (scramble && i == 0) begin
        a = $urandom;
        b = $urandom;
      end
    end
    divsel = 3'd0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    string       name;
    logic [2:0]  sel;
    logic [31:0] av;
    logic [31:0] bv;
    logic [31:0] exp_res;
    int          lat;
    bit          scramble;
  } vec_t;

  vec_t vecs[$];

  // ---------------- stimulus ----------------
  initial begin
    rst    = 1'b0;
    divsel = 3'd0;
    a      = 32'h0;
    b      = 32'h0;
    idle_cycles(3);
    check("reset_ready", {31'h0, ready}, 32'h0);
    check("reset_res", res, 32'h0);
    rst = 1'b1;
    idle_cycles(1);

    vecs = '{
      '{"divu_100_7",      3'd2, 32'd100,       32'd7,         32'd14,        LAT_NORMAL,  1'b1},
      '{"rem_m7_2",        3'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, LAT_NORMAL,  1'b0},
      '{"div_m7_2",        3'd1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, LAT_NORMAL,  1'b0},
      '{"div_7_m2",        3'd1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT_NORMAL,  1'b0},
      '{"rem_7_m2",        3'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         LAT_NORMAL,  1'b0},
      '{"div_m100_m7",     3'd1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        LAT_NORMAL,  1'b0},
      '{"rem_m100_m7",     3'd3, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, LAT_NORMAL,  1'b0},
      '{"divu_max_10",     3'd2, 32'hFFFF_FFFF, 32'd10,        32'h1999_9999, LAT_NORMAL,  1'b0},
      '{"remu_max_10",     3'd4, 32'hFFFF_FFFF, 32'd10,        32'd5,         LAT_NORMAL,  1'b0},
      '{"remu_3_5",        3'd4, 32'd3,         32'd5,         32'd3,         LAT_NORMAL,  1'b0},
      '{"divu_min_m1",     3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LAT_NORMAL,  1'b0},
      '{"div_min_1",       3'd1, 32'h8000_0000, 32'd1,         32'h8000_0000, LAT_NORMAL,  1'b0},
      '{"div_ovf",         3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SPECIAL, 1'b0},
      '{"rem_ovf",         3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LAT_SPECIAL, 1'b0},
      '{"remu_5_0",        3'd4, 32'd5,         32'd0,         32'd5,         LAT_SPECIAL, 1'b0},
      '{"div_m7_0",        3'd1, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, LAT_SPECIAL, 1'b0},
      '{"rem_m7_0",        3'd3, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, LAT_SPECIAL, 1'b0},
      '{"divu_9_0",        3'd2, 32'd9,         32'd0,         32'hFFFF_FFFF, LAT_SPECIAL, 1'b0}
    };

    foreach (vecs[i]) begin
      run_op(vecs[i].name, vecs[i].sel, vecs[i].av, vecs[i].bv,
             vecs[i].exp_res, vecs[i].lat, vecs[i].scramble);
    end

    // Back-to-back: divsel held through DONE restarts in the following IDLE.
    divsel = 3'd2;
    a      = 32'd100;
    b      = 32'd7;
    sb_push("b2b_first", 32'd14, cyc + 33);
    sb_push("b2b_second", 32'd14, cyc + 67);
    idle_cycles(67);
    divsel = 3'd0;
    idle_cycles(1);

    // Abort at cycle 10: no ready pulse, res keeps the last result (14).
    divsel = 3'd2;
    a      = 32'd1000;
    b      = 32'd3;
    idle_cycles(10);
    divsel = 3'd0;
    idle_cycles(40);
    check("abort_res_held", res, 32'd14);
    run_op("divu_9_3_after_abort", 3'd2, 32'd9, 32'd3, 32'd3, LAT_NORMAL, 1'b0);

    // Reset at cycle 15 of an operation.
    divsel = 3'd2;
    a      = 32'd1000;
    b      = 32'd10;
    idle_cycles(15);
    rst    = 1'b0;
    divsel = 3'd0;
    idle_cycles(1);
    check("midop_reset_ready", {31'h0, ready}, 32'h0);
    check("midop_reset_res", res, 32'h0);
    rst = 1'b1;
    idle_cycles(40);
    check("post_reset_res_held", res, 32'h0);
    run_op("divu_1000_10_after_reset", 3'd2, 32'd1000, 32'd10, 32'd100,
           LAT_NORMAL, 1'b0);

    // Reserved selects behave as none: nothing starts.
    divsel = 3'd5;
    a      = 32'd50;
    b      = 32'd5;
    idle_cycles(20);
    divsel = 3'd7;
    idle_cycles(20);
    divsel = 3'd0;
    idle_cycles(20);
    check("reserved_sel_res_held", res, 32'd100);

    idle_cycles(5);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
